// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared op encodings, FSM states and default widths for the vmem LSU
package vmem_pkg;

  localparam int VMEM_AW = 8;
  localparam int VMEM_DW = 8;

  localparam logic [1:0] OP_ADDI  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RWAIT
  } lsu_state_t;

endpackage

// File: rtl/vmem_lsu_rf.sv
// rtl/vmem_lsu_rf.sv - NREG x DW register file, one write port, two async read ports
module vmem_lsu_rf #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  parameter int RAW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [RAW-1:0]      waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [RAW-1:0]      ra_a,
  input  logic [RAW-1:0]      ra_b,
  output logic [DW-1:0]       rd_a,
  output logic [DW-1:0]       rd_b,
  output logic [NREG*DW-1:0]  rf_flat
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (we) begin
      rf_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        rf_q[i] <= '0;
      end else begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign rd_a = rf_q[ra_a];
  assign rd_b = rf_q[ra_b];

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign rf_flat[i*DW +: DW] = rf_q[i];
  end

endmodule

// File: rtl/vmem_lsu.sv
// rtl/vmem_lsu.sv - single-outstanding load/store unit with request/grant memory port
// Optional first-store write log enabled by VMEM_LSU_WR_LOG_EN.
module vmem_lsu
  import vmem_pkg::*;
#(
  parameter int AW   = VMEM_AW,
  parameter int DW   = VMEM_DW,
  parameter int NREG = 4,
  parameter int RAW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [RAW-1:0]      in_rd,
  input  logic [RAW-1:0]      in_rs,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DW-1:0]       mem_rdata,
  output logic                done,
  output logic [NREG*DW-1:0]  rf_flat
`ifdef VMEM_LSU_WR_LOG_EN
  ,
  output logic                wlog_e,
  output logic [AW-1:0]       wlog_a,
  output logic [DW-1:0]       wlog_d
`endif
);

  lsu_state_t     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [RAW-1:0] dest_q, dest_d;
  logic           done_q, done_d;

  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [DW-1:0]  rd_a, rd_b;
  logic [AW-1:0]  addr_a, addr_b;

  vmem_lsu_rf #(.NREG(NREG), .DW(DW), .RAW(RAW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_a    (in_rd),
    .ra_b    (in_rs),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .rf_flat (rf_flat)
  );

  // Register values become addresses by zero-extension or truncation.
  if (AW > DW) begin : g_zext
    assign addr_a = {{(AW-DW){1'b0}}, rd_a};
    assign addr_b = {{(AW-DW){1'b0}}, rd_b};
  end else begin : g_trunc
    assign addr_a = rd_a[AW-1:0];
    assign addr_b = rd_b[AW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    dest_d   = dest_q;
    done_d   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = in_rd;
    rf_wdata = rd_b + DW'(1);
    in_ready = 1'b0;
    mem_req  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_op)
            OP_ADDI: begin
              rf_we  = 1'b1;
              done_d = 1'b1;
            end
            OP_STORE: begin
              addr_d  = addr_a;
              wdata_d = rd_b;
              we_d    = 1'b1;
              state_d = REQ;
            end
            OP_LOAD: begin
              addr_d  = addr_b;
              dest_d  = in_rd;
              we_d    = 1'b0;
              state_d = REQ;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RWAIT;
          end
        end
      end
      RWAIT: begin
        if (mem_rvalid) begin
          rf_we    = 1'b1;
          rf_waddr = dest_q;
          rf_wdata = mem_rdata;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;

`ifdef VMEM_LSU_WR_LOG_EN
  logic          wlog_e_q, wlog_e_d;
  logic [AW-1:0] wlog_a_q, wlog_a_d;
  logic [DW-1:0] wlog_d_q, wlog_d_d;

  // Only the first granted store after reset is recorded.
  always_comb begin
    wlog_e_d = wlog_e_q;
    wlog_a_d = wlog_a_q;
    wlog_d_d = wlog_d_q;
    if (state_q == REQ && mem_gnt && we_q && !wlog_e_q) begin
      wlog_e_d = 1'b1;
      wlog_a_d = addr_q;
      wlog_d_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wlog_e_q <= 1'b0;
      wlog_a_q <= '0;
      wlog_d_q <= '0;
    end else begin
      wlog_e_q <= wlog_e_d;
      wlog_a_q <= wlog_a_d;
      wlog_d_q <= wlog_d_d;
    end
  end

  assign wlog_e = wlog_e_q;
  assign wlog_a = wlog_a_q;
  assign wlog_d = wlog_d_q;
`endif

endmodule
